bu2020_mem_responder: RTL

- Memory-side responder for the BU2020 core. It is the other end of the core's instruction bus and data bus.
- Holds a 4096x16 instruction array and a 4096x16 data array.
- Answers instruction fetches and data reads combinationally, so the core samples them at the next posedge.
- Core stores go through a write-posting buffer that drains into a slow data array.
- A boot loader FSM fills both arrays before the core is released.

---
 rtl/bu2020_mem_pkg.sv | 17 +
 rtl/bu2020_wbuf.sv | 73 +++++++
 rtl/bu2020_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/bu2020_mem_pkg.sv
// rtl/bu2020_mem_pkg.sv - shared widths, types and defaults for the BU2020 memory responder
package bu2020_mem_pkg;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] NOP_WORD_DEFAULT = 16'hD000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } load_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/bu2020_wbuf.sv
// rtl/bu2020_wbuf.sv - posted-write FIFO with fixed-latency drain and youngest-match forwarding
module bu2020_wbuf
  import bu2020_mem_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int WR_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  wbuf_entry_t       push_entry_i,
  output logic              drop_o,
  output logic              pop_o,
  output wbuf_entry_t       head_o,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (WR_LATENCY > 1) ? $clog2(WR_LATENCY) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(WR_LATENCY - 1);
  localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(DEPTH);

  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] drain_q, drain_d;
  logic          accept;

  always_comb begin
    pop_o    = (count_q != '0) && (drain_q == DRAIN_LAST);
    // A full buffer still takes the write when the head leaves on the same edge.
    accept   = push_i && ((count_q != FULL_CNT) || pop_o);
    drop_o   = push_i && !accept;
    wr_ptr_d = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_o ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop_o};
    drain_d  = ((count_q == '0) || pop_o) ? '0 : drain_q + CW'(1);
    head_o   = mem_q[rd_ptr_q];
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (((PW + 1)'(i) < count_q) && (mem_q[idx].addr == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[idx].data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= push_entry_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drain_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drain_q  <= drain_d;
    end
  end
endmodule

// File: rtl/bu2020_mem_responder.sv
// rtl/bu2020_mem_responder.sv - BU2020 instruction/data memory responder with boot loader and posted writes
// Optional write/drop statistics ports: BU2020_MEM_STATS_EN
module bu2020_mem_responder
  import bu2020_mem_pkg::*;
#(
  parameter int                WBUF_DEPTH = 4,
  parameter int                WR_LATENCY = 3,
  parameter logic [DATA_W-1:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic [DATA_W-1:0] instr_data,
  input  logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  input  logic              mem_wr,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              load_sel,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
  input  logic              load_done,
  output logic              cpu_run,
  output logic              wbuf_overflow
`ifdef BU2020_MEM_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       drop_count
`endif
);
  load_state_t       state_q;
  logic              load_ready_q, cpu_run_q, overflow_q;
  logic [DATA_W-1:0] iarray [MEM_WORDS];
  logic [DATA_W-1:0] darray [MEM_WORDS];

  logic              load_xfer, core_wr, rd_en;
  logic              wb_drop, wb_pop, wb_hit;
  logic [DATA_W-1:0] wb_hit_data, rd_data;
  wbuf_entry_t       wb_head, push_entry;

  assign load_xfer       = (state_q == ST_LOAD) && load_valid && load_ready_q;
  assign core_wr         = (state_q == ST_RUN) && mem_wr;
  assign rd_en           = (state_q == ST_RUN) && !mem_wr;
  assign push_entry.addr = mem_addr;
  assign push_entry.data = mem_data;

  bu2020_wbuf #(
    .DEPTH      (WBUF_DEPTH),
    .WR_LATENCY (WR_LATENCY)
  ) u_wbuf (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (core_wr),
    .push_entry_i  (push_entry),
    .drop_o        (wb_drop),
    .pop_o         (wb_pop),
    .head_o        (wb_head),
    .lookup_addr_i (mem_addr),
    .hit_o         (wb_hit),
    .hit_data_o    (wb_hit_data)
  );

  assign rd_data    = wb_hit ? wb_hit_data : darray[mem_addr];
  assign mem_data   = rd_en ? rd_data : {DATA_W{1'bz}};
  assign instr_data = (state_q == ST_RUN) ? iarray[instr_addr] : NOP_WORD;

  assign load_ready    = load_ready_q;
  assign cpu_run       = cpu_run_q;
  assign wbuf_overflow = overflow_q;

  // Loader writes only happen in ST_LOAD and drains only in ST_RUN, so they never collide.
  always_ff @(posedge clk) begin
    if (load_xfer && !load_sel) iarray[load_addr] <= load_wdata;
    if (load_xfer && load_sel) darray[load_addr] <= load_wdata;
    else if (wb_pop) darray[wb_head.addr] <= wb_head.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      load_ready_q <= 1'b1;
      cpu_run_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_done) begin
            state_q      <= ST_RUN;
            load_ready_q <= 1'b0;
            cpu_run_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wb_drop) overflow_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef BU2020_MEM_STATS_EN
  logic [15:0] wr_count_q, drop_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      if (core_wr && !wb_drop && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
      if (wb_drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign wr_count   = wr_count_q;
  assign drop_count = drop_count_q;
`endif
endmodule
